// File: rtl/bmp_pkg.sv
// Shared constants and FSM encoding for the BMP image streamer.
package bmp_pkg;

    localparam int BYTE_WIDTH_DEF     = 8;
    localparam int ADDR_WIDTH_DEF     = 20;
    localparam int BMP_TOTAL_SIZE_DEF = 786486;

    // "BM" signature at the start of every BMP file
    localparam logic [7:0] BMP_MAGIC0 = 8'h42;
    localparam logic [7:0] BMP_MAGIC1 = 8'h4D;

    // Read data buffer depth (occupancy plus in-flight reads never exceeds this)
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } bmp_state_e;

endpackage

// File: rtl/bmp_byte_fifo.sv
// Two-entry byte FIFO with occupancy count; push and pop may share a cycle.
module bmp_byte_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is only legal when a pop frees a slot the same cycle
    assign push_ok = push && ((count != 2'd2) || pop);
    assign pop_ok  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/store_bmp.sv
// Streams a buffered BMP image from a single-port byte RAM onto a valid/ready
// byte stream, checking the "BM" signature and the file-size header field.
module store_bmp
    import bmp_pkg::*;
#(
    parameter int BYTE_WIDTH     = BYTE_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int BMP_TOTAL_SIZE = BMP_TOTAL_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  RAM_ren,
    output logic                  RAM_wen,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    input  logic [BYTE_WIDTH-1:0] RAM_out,
    output logic                  out_valid,
    output logic [BYTE_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  hdr_err,
    output logic                  size_err,
    output bmp_state_e            fsm_state
);

    // Stream handshake: a byte moves when out_valid and out_ready are both high
    // at a rising edge; while out_valid is high and out_ready low, out_valid and
    // out_data hold their values until the transfer happens.

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BMP_TOTAL_SIZE - 1);
    localparam logic [31:0]           LAST_IDX  = 32'(BMP_TOTAL_SIZE - 1);
    localparam logic [31:0]           SIZE_WORD = 32'(BMP_TOTAL_SIZE);

    bmp_state_e            state;
    bmp_state_e            state_n;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  in_flight;
    logic [1:0]            fifo_count;
    logic [2:0]            pending;
    logic                  pop;
    logic                  ren;
    logic                  start_ok;
    logic                  last_read;
    logic                  last_xfer;
    logic [31:0]           xfer_cnt;
    logic [7:0]            hdr_byte;
    logic                  hdr_bad;
    logic                  hdr_bad_n;
    logic [31:0]           size_field;
    logic [31:0]           size_n;

    bmp_byte_fifo #(
        .WIDTH (BYTE_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight),
        .push_data (RAM_out),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign last_read = (rd_addr == LAST_ADDR);
    assign last_xfer = pop && (xfer_cnt == LAST_IDX);
    assign hdr_byte  = 8'(out_data);

    // Bytes already committed to the buffer, minus the one leaving this cycle.
    // Counting the departing byte as free is what sustains one byte per cycle.
    assign pending = 3'(fifo_count) + 3'(in_flight) - 3'(pop);

    assign RAM_ren   = ren;
    assign RAM_wen   = 1'b0;
    assign RAM_addr  = rd_addr;
    assign busy      = (state == ST_STREAM) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, start acceptance and RAM read issue
    always_comb begin
        state_n  = state;
        ren      = 1'b0;
        start_ok = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_n  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pending < 3'(FIFO_DEPTH)) begin
                    ren = 1'b1;
                    if (last_read) begin
                        state_n = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_xfer) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_n  = ST_STREAM;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Read address and in-flight tracking; a reset drops any returning datum
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= ren;
            if (start_ok) begin
                rd_addr <= '0;
            end else if (ren && !last_read) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // Header inspection of the byte leaving the stream this cycle
    always_comb begin
        hdr_bad_n = hdr_bad;
        size_n    = size_field;
        if (pop && (xfer_cnt < 32'd6)) begin
            case (xfer_cnt[2:0])
                3'd0:    hdr_bad_n = hdr_bad | (hdr_byte != BMP_MAGIC0);
                3'd1:    hdr_bad_n = hdr_bad | (hdr_byte != BMP_MAGIC1);
                3'd2:    size_n[7:0]   = hdr_byte;
                3'd3:    size_n[15:8]  = hdr_byte;
                3'd4:    size_n[23:16] = hdr_byte;
                3'd5:    size_n[31:24] = hdr_byte;
                default: size_n = size_field;
            endcase
        end
    end

    // Transfer count, header accumulation and error flags published at the end
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            xfer_cnt   <= '0;
            hdr_bad    <= 1'b0;
            size_field <= '0;
            hdr_err    <= 1'b0;
            size_err   <= 1'b0;
        end else begin
            hdr_bad    <= hdr_bad_n;
            size_field <= size_n;
            if (pop) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
            // Images shorter than the header cannot carry a valid signature or size
            if (last_xfer) begin
                hdr_err  <= hdr_bad_n | (BMP_TOTAL_SIZE < 2);
                size_err <= (BMP_TOTAL_SIZE < 6) | (size_n != SIZE_WORD);
            end
        end
    end

endmodule

// File: tb/tb_store_bmp.sv
// Bench for store_bmp: random image contents, random back-pressure, reset and
// restart scenarios, plus a one-byte image instance.
module tb_store_bmp;
    import bmp_pkg::*;

    localparam int BW  = 8;
    localparam int AW  = 20;
    localparam int TOT = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (64-byte image) ----------------
    logic          start = 1'b0;
    logic          ram_ren;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_out = '0;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          hdr_err;
    logic          size_err;
    bmp_state_e    fsm_state;

    store_bmp #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .BMP_TOTAL_SIZE(TOT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .RAM_ren(ram_ren), .RAM_wen(ram_wen), .RAM_addr(ram_addr), .RAM_out(ram_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .hdr_err(hdr_err), .size_err(size_err),
        .fsm_state(fsm_state)
    );

    // ---------------- DUT (one-byte image) ----------------
    logic          start1 = 1'b0;
    logic          ren1;
    logic          wen1;
    logic [AW-1:0] addr1;
    logic [BW-1:0] ram_out1 = '0;
    logic          valid1;
    logic [BW-1:0] data1;
    logic          busy1;
    logic          done1;
    logic          hdr1;
    logic          size1;
    bmp_state_e    state1;

    store_bmp #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .BMP_TOTAL_SIZE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .RAM_ren(ren1), .RAM_wen(wen1), .RAM_addr(addr1), .RAM_out(ram_out1),
        .out_valid(valid1), .out_data(data1), .out_ready(1'b1),
        .busy(busy1), .done(done1), .hdr_err(hdr1), .size_err(size1),
        .fsm_state(state1)
    );

    // ---------------- RAM models (data one cycle after read enable) ----------------
    logic [7:0] img [TOT];

    always @(posedge clk) if (ram_ren) ram_out <= img[ram_addr[5:0]];
    always @(posedge clk) if (ren1) ram_out1 <= (addr1 == '0) ? 8'h42 : 8'hEE;

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stream monitor: read order, buffer credit, byte order, stall stability
    int            n_reads = 0;
    int            n_xfers = 0;
    int            first_xfer_cyc = 0;
    int            last_xfer_cyc = 0;
    logic          stall_q = 1'b0;
    logic [BW-1:0] stall_data = '0;
    logic          fire;
    logic          ready_rand = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            fire = out_valid && out_ready;
            if (stall_q) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_data);
            end
            if (ram_ren) begin
                check("rd_addr", ram_addr, n_reads);
                check("rd_credit", (n_reads - n_xfers - int'(fire)) <= 1, 1);
                n_reads++;
            end
            if (fire) begin
                if (exp_q.size() == 0) check("extra_byte", 1, 0);
                else check("out_data", out_data, exp_q.pop_front());
                if (n_xfers == 0) first_xfer_cyc = cyc + 1;
                n_xfers++;
                last_xfer_cyc = cyc + 1;
            end
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    // Back-pressure driver
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // ---------------- reference model ----------------
    task automatic build_image(input logic good);
        for (int i = 0; i < TOT; i++) img[i] = 8'($urandom_range(0, 255));
        img[0] = good ? 8'h42 : 8'h00;
        img[1] = 8'h4D;
        img[2] = good ? 8'h40 : 8'h41;
        img[3] = 8'h00;
        img[4] = 8'h00;
        img[5] = 8'h00;
    endtask

    function automatic logic model_hdr_err();
        return (img[0] != 8'h42) || (img[1] != 8'h4D);
    endfunction

    function automatic logic model_size_err();
        return {img[5], img[4], img[3], img[2]} != 32'(TOT);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic begin_run();
        exp_q.delete();
        for (int i = 0; i < TOT; i++) exp_q.push_back(img[i]);
        n_reads = 0;
        n_xfers = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_xfers(input int n);
        int hit;
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (n_xfers >= n) begin
                hit = 1;
                break;
            end
        end
        if (hit == 0) check("xfer_timeout", n_xfers, n);
    endtask

    task automatic end_checks();
        repeat (3) @(negedge clk);
        check("bytes_out", n_xfers, TOT);
        check("reads", n_reads, TOT);
        check("exp_left", exp_q.size(), 0);
        check("done_hold", done, 1);
        check("busy_at_done", busy, 0);
        check("state_done", fsm_state, ST_DONE);
        check("hdr_err", hdr_err, model_hdr_err());
        check("size_err", size_err, model_size_err());
    endtask

    task automatic reset_checks();
        check("rst_ren", ram_ren, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hdr", hdr_err, 0);
        check("rst_size", size_err, 0);
        check("rst_state", fsm_state, ST_IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dc;
        int n1;
        int r1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks();

        // Valid header, ready held high: latency, throughput, done timing
        build_image(1'b1);
        begin_run();
        pulse_start();
        @(negedge clk);
        check("first_ren", ram_ren, 1);
        check("busy_start", busy, 1);
        check("valid_c0", out_valid, 0);
        @(negedge clk);
        check("valid_c1", out_valid, 0);
        @(negedge clk);
        check("valid_c2", out_valid, 1);
        wait_done(300, dc);
        check("done_latency", dc, last_xfer_cyc);
        check("sustained", last_xfer_cyc - first_xfer_cyc, TOT - 1);
        end_checks();

        // Random back-pressure on a fresh payload
        ready_rand = 1'b1;
        build_image(1'b1);
        begin_run();
        pulse_start();
        wait_done(2000, dc);
        end_checks();

        // Bad signature and size field, still fully streamed
        build_image(1'b0);
        begin_run();
        pulse_start();
        wait_done(2000, dc);
        end_checks();
        ready_rand = 1'b0;

        // Reset in the middle of the stream, then a clean restart
        build_image(1'b1);
        begin_run();
        pulse_start();
        wait_xfers(20);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        begin_run();
        @(negedge clk);
        reset_checks();
        pulse_start();
        wait_done(300, dc);
        end_checks();

        // Start while busy is ignored; start in DONE clears flags and restarts
        build_image(1'b0);
        begin_run();
        pulse_start();
        wait_xfers(10);
        pulse_start();
        wait_done(300, dc);
        end_checks();
        begin_run();
        pulse_start();
        @(negedge clk);
        check("restart_done_clr", done, 0);
        check("restart_hdr_clr", hdr_err, 0);
        check("restart_size_clr", size_err, 0);
        check("restart_busy", busy, 1);
        wait_done(300, dc);
        end_checks();

        // One-byte image
        n1 = 0;
        r1 = 0;
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ren1) begin
                check("one_addr", addr1, 0);
                r1++;
            end
            if (valid1) begin
                check("one_data", data1, 8'h42);
                n1++;
            end
            if (done1) break;
        end
        check("one_done", done1, 1);
        check("one_bytes", n1, 1);
        check("one_reads", r1, 1);
        check("one_hdr_err", hdr1, 1);
        check("one_size_err", size1, 1);
        check("one_busy", busy1, 0);
        check("one_wen", wen1, 0);
        check("one_state", state1, ST_DONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/store_bmp.md
STORE_BMP -- requirements
Module: store_bmp

Interface
REQ-001 SHALL have parameter BYTE_WIDTH, default 8, width of one image byte.
REQ-002 SHALL have parameter ADDR_WIDTH, default 20, width of RAM byte address.
REQ-003 SHALL have parameter BMP_TOTAL_SIZE, default 786486, number of bytes streamed.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst  in  1  synchronous active-high reset.
REQ-006 SHALL have start  in  1  one-cycle request to stream the buffered image; ignored unless idle or done.
REQ-007 SHALL have RAM_ren  out  1  read enable to the single-port byte RAM.
REQ-008 SHALL have RAM_wen  out  1  write enable, tied 0.
REQ-009 SHALL have RAM_addr  out  ADDR_WIDTH  read byte address.
REQ-010 SHALL have RAM_out  in  BYTE_WIDTH  RAM read data, valid exactly one cycle after RAM_ren.
REQ-011 SHALL have out_valid  out  1, out_data  out  BYTE_WIDTH, out_ready  in  1: byte stream, transfer when valid and ready both high at a rising edge.
REQ-012 SHALL have busy  out  1  high from accepted start until done rises.
REQ-013 SHALL have done  out  1  high from the cycle after the last transfer until next accepted start or reset.
REQ-014 SHALL have hdr_err  out  1  and size_err  out  1, valid while done is high.

Function
REQ-015 SHALL use FSM IDLE -> STREAM (on start) -> DRAIN (last read issued) -> DONE (last byte transferred) -> STREAM (on start).
REQ-016 SHALL read addresses 0 to BMP_TOTAL_SIZE-1 in ascending order, each exactly once per start.
REQ-017 SHALL emit bytes on out_data in address order, unmodified.
REQ-018 SHALL buffer RAM data in a 2-entry FIFO; a read is issued only when FIFO occupancy plus in-flight reads is below 2.
REQ-019 SHALL, with out_ready held high, issue the first RAM_ren in the cycle after start and raise out_valid 2 cycles after start, then sustain 1 byte per cycle.
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0; no byte lost or duplicated under any out_ready pattern.
REQ-021 SHALL set hdr_err if byte0 != 8'h42 or byte1 != 8'h4D.
REQ-022 SHALL set size_err if bytes 2..5, little-endian 32-bit, differ from BMP_TOTAL_SIZE (compared zero-extended to 32 bits).
REQ-023 SHALL still stream the full image when hdr_err or size_err is set.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL clear hdr_err, size_err and done in the cycle after an accepted start.
REQ-026 SHALL treat BMP_TOTAL_SIZE=1 correctly (single byte, then DONE; hdr_err=1, size_err=1).

Reset
REQ-027 SHALL, on rst=1 at a rising edge, enter IDLE, empty the FIFO, cancel in-flight reads, and drive RAM_ren=0, RAM_addr=0, out_valid=0, out_data=0, busy=0, done=0, hdr_err=0, size_err=0.
REQ-028 SHALL, on reset mid-stream, discard the RAM datum returning in the following cycle.

Structure
REQ-029 SHALL take BYTE_WIDTH, ADDR_WIDTH, BMP_TOTAL_SIZE defaults, BMP magic bytes and FSM state encoding from shared package bmp_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module bmp_byte_fifo (depth 2, occupancy count, push/pop same cycle allowed).

Verification
REQ-031 SHALL cover: BMP_TOTAL_SIZE=64, valid header (42 4D 40 00 00 00), out_ready=1 -> 64 bytes in order, first out_valid 2 cycles after start, done 1 cycle after last transfer, hdr_err=0, size_err=0.
REQ-032 SHALL cover: out_ready random 50% duty -> identical 64-byte sequence, no RAM_ren when FIFO+in-flight=2, out_data stable during stalls.
REQ-033 SHALL cover: byte0=8'h00, size field 8'h41 -> full 64 bytes, then hdr_err=1, size_err=1.
REQ-034 SHALL cover: rst at byte 20, then start -> outputs at reset values, restart from address 0, 64 clean bytes.
REQ-035 SHALL cover: start pulsed at byte 10 of stream -> ignored, exactly 64 bytes; second start in DONE -> flags cleared, second full stream.
